// File: rtl/lc3_writeback_stage.sv
// LC-3 writeback stage: result select, 8x16 register file, NZP condition codes and read ports.
// Optional define LC3_WB_BYPASS_EN adds same-cycle write-through forwarding onto VSR1/VSR2.
module lc3_writeback_stage #(
   parameter int unsigned DATA_W   = 16,
   parameter int unsigned NUM_REGS = 8,
   localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              enable_writeback,
   input  logic [1:0]        W_Control,
   input  logic [DATA_W-1:0] aluout,
   input  logic [DATA_W-1:0] memout,
   input  logic [DATA_W-1:0] pcout,
   input  logic [IDX_W-1:0]  dr,
   input  logic [IDX_W-1:0]  sr1,
   input  logic [IDX_W-1:0]  sr2,
   output logic [2:0]        psr,
   output logic [DATA_W-1:0] VSR1,
   output logic [DATA_W-1:0] VSR2
);

   localparam logic [1:0] SEL_ALU = 2'b00;
   localparam logic [1:0] SEL_MEM = 2'b01;
   localparam logic [1:0] SEL_PC  = 2'b10;
   localparam logic [1:0] SEL_RSV = 2'b11;

   logic [DATA_W-1:0] rf_q [NUM_REGS];
   logic [2:0]        psr_q;
   logic [2:0]        psr_d;
   logic [DATA_W-1:0] wb_data;
   logic              wr_en;

   // Writeback source select and NZP classification of the selected value
   always_comb begin
      wb_data = '0;
      psr_d   = psr_q;
      wr_en   = enable_writeback && (W_Control != SEL_RSV);
      case (W_Control)
         SEL_ALU: wb_data = aluout;
         SEL_MEM: wb_data = memout;
         SEL_PC:  wb_data = pcout;
         default: wb_data = '0;
      endcase
      if (wr_en) begin
         if (wb_data[DATA_W-1])    psr_d = 3'b100;
         else if (wb_data == '0)   psr_d = 3'b010;
         else                      psr_d = 3'b001;
      end
   end

   // Register file and condition codes; reset clears everything immediately
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
            rf_q[i] <= '0;
         end
         psr_q <= 3'b000;
      end else begin
         if (wr_en) begin
            rf_q[dr] <= wb_data;
         end
         psr_q <= psr_d;
      end
   end

   assign psr = psr_q;

`ifdef LC3_WB_BYPASS_EN
   logic byp1;
   logic byp2;

   // Forward the value being written when a read port targets the destination
   always_comb begin
      byp1 = reset && wr_en && (sr1 == dr);
      byp2 = reset && wr_en && (sr2 == dr);
      VSR1 = byp1 ? wb_data : rf_q[sr1];
      VSR2 = byp2 ? wb_data : rf_q[sr2];
   end
`else
   assign VSR1 = rf_q[sr1];
   assign VSR2 = rf_q[sr2];
`endif

endmodule

// File: tb/tb_lc3_writeback_stage.sv
// Randomized self-checking bench for lc3_writeback_stage against a register-array reference model.
module tb_lc3_writeback_stage;

   logic        clock;
   logic        reset;
   logic        enable_writeback;
   logic [1:0]  W_Control;
   logic [15:0] aluout;
   logic [15:0] memout;
   logic [15:0] pcout;
   logic [2:0]  dr;
   logic [2:0]  sr1;
   logic [2:0]  sr2;
   logic [2:0]  psr;
   logic [15:0] VSR1;
   logic [15:0] VSR2;

   int total;
   int bad;

   logic [15:0] ref_rf [8];
   logic [2:0]  ref_psr;

`ifdef LC3_WB_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   lc3_writeback_stage dut (
      .clock            (clock),
      .reset            (reset),
      .enable_writeback (enable_writeback),
      .W_Control        (W_Control),
      .aluout           (aluout),
      .memout           (memout),
      .pcout            (pcout),
      .dr               (dr),
      .sr1              (sr1),
      .sr2              (sr2),
      .psr              (psr),
      .VSR1             (VSR1),
      .VSR2             (VSR2)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [15:0] sel_value(input logic [1:0] wc, input logic [15:0] a,
                                             input logic [15:0] m, input logic [15:0] p);
      if (wc == 2'd0) return a;
      if (wc == 2'd1) return m;
      return p;
   endfunction

   function automatic logic [2:0] nzp(input logic [15:0] v);
      if ($signed(v) < 0) return 3'b100;
      if (v == 16'd0)     return 3'b010;
      return 3'b001;
   endfunction

   function automatic bit writes_now();
      return reset && enable_writeback && (W_Control != 2'b11);
   endfunction

   function automatic logic [15:0] exp_read(input logic [2:0] s);
      if (BYPASS && writes_now() && s == dr)
         return sel_value(W_Control, aluout, memout, pcout);
      return ref_rf[s];
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) ref_rf[i] = 16'h0000;
      ref_psr = 3'b000;
   endfunction

   // One rising edge with the current inputs, then the model follows; returns at the next falling edge
   task automatic step();
      logic [15:0] v;
      @(posedge clock);
      if (writes_now()) begin
         v          = sel_value(W_Control, aluout, memout, pcout);
         ref_rf[dr] = v;
         ref_psr    = nzp(v);
      end
      @(negedge clock);
   endtask

   task automatic idle_inputs();
      enable_writeback = 1'b0;
      W_Control        = 2'b00;
      aluout           = 16'h0000;
      memout           = 16'h0000;
      pcout            = 16'h0000;
      dr               = 3'd0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      idle_inputs();
      sr1 = 3'd0;
      sr2 = 3'd0;
      model_reset();
      repeat (3) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i);
         sr2 = 3'(7 - i);
         #1;
         total++;
         if (VSR1 !== 16'h0000 || VSR2 !== 16'h0000 || psr !== 3'b000) begin
            bad++;
            $display("FAIL reset_sweep i=%0d got VSR1=%h VSR2=%h psr=%b want 0000 0000 000",
                     i, VSR1, VSR2, psr);
         end
      end
      reset = 1'b1;
      @(negedge clock);
      total++;
      if (psr !== 3'b000 || VSR1 !== 16'h0000) begin
         bad++;
         $display("FAIL reset_release got psr=%b VSR1=%h want 000 0000", psr, VSR1);
      end
   endtask

   task automatic test_alu_mem();
      enable_writeback = 1'b1; W_Control = 2'b00; aluout = 16'h8000; dr = 3'd3;
      step();
      enable_writeback = 1'b0; sr1 = 3'd3;
      #1;
      total++;
      if (VSR1 !== 16'h8000 || psr !== 3'b100) begin
         bad++;
         $display("FAIL alu_write got VSR1=%h psr=%b want 8000 100", VSR1, psr);
      end
      enable_writeback = 1'b1; W_Control = 2'b01; memout = 16'h0005; dr = 3'd4;
      step();
      enable_writeback = 1'b0; sr2 = 3'd4;
      #1;
      total++;
      if (VSR2 !== 16'h0005 || psr !== 3'b001) begin
         bad++;
         $display("FAIL mem_write got VSR2=%h psr=%b want 0005 001", VSR2, psr);
      end
   endtask

   task automatic test_zero_pc();
      enable_writeback = 1'b1; W_Control = 2'b10; pcout = 16'h0000; dr = 3'd7;
      aluout = 16'h7777;
      step();
      enable_writeback = 1'b0; sr1 = 3'd7;
      #1;
      total++;
      if (VSR1 !== 16'h0000 || psr !== 3'b010) begin
         bad++;
         $display("FAIL pc_zero_write got VSR1=%h psr=%b want 0000 010", VSR1, psr);
      end
      enable_writeback = 1'b0; W_Control = 2'b00; aluout = 16'h1234; dr = 3'd7;
      step();
      #1;
      total++;
      if (VSR1 !== 16'h0000 || psr !== 3'b010) begin
         bad++;
         $display("FAIL disabled_hold got VSR1=%h psr=%b want 0000 010", VSR1, psr);
      end
   endtask

   task automatic test_reserved();
      logic [15:0] old2;
      logic [2:0]  oldp;
      enable_writeback = 1'b1; W_Control = 2'b00; aluout = 16'h0042; dr = 3'd2;
      step();
      old2 = 16'h0042;
      oldp = 3'b001;
      enable_writeback = 1'b1; W_Control = 2'b11; aluout = 16'hFFFF;
      memout = 16'hFFFF; pcout = 16'hFFFF; dr = 3'd2;
      step();
      enable_writeback = 1'b0; sr1 = 3'd2;
      #1;
      total++;
      if (VSR1 !== old2 || psr !== oldp) begin
         bad++;
         $display("FAIL reserved_select got VSR1=%h psr=%b want %h %b", VSR1, psr, old2, oldp);
      end
   endtask

   task automatic test_mid_reset();
      enable_writeback = 1'b1; W_Control = 2'b00; aluout = 16'hABCD; dr = 3'd1;
      step();
      sr1 = 3'd1; sr2 = 3'd3;
      #1;
      total++;
      if (VSR1 !== 16'hABCD || psr !== 3'b100) begin
         bad++;
         $display("FAIL pre_reset_write got VSR1=%h psr=%b want abcd 100", VSR1, psr);
      end
      aluout = 16'h5555;
      #1 reset = 1'b0;
      model_reset();
      #1;
      total++;
      if (VSR1 !== 16'h0000 || VSR2 !== 16'h0000 || psr !== 3'b000) begin
         bad++;
         $display("FAIL async_reset got VSR1=%h VSR2=%h psr=%b want 0000 0000 000", VSR1, VSR2, psr);
      end
      step();
      reset = 1'b1;
      enable_writeback = 1'b1; W_Control = 2'b01; memout = 16'h0101; dr = 3'd6;
      step();
      enable_writeback = 1'b0; sr1 = 3'd6; sr2 = 3'd1;
      #1;
      total++;
      if (VSR1 !== 16'h0101 || VSR2 !== 16'h0000 || psr !== 3'b001) begin
         bad++;
         $display("FAIL first_write_after_reset got VSR1=%h VSR2=%h psr=%b want 0101 0000 001",
                  VSR1, VSR2, psr);
      end
   endtask

   task automatic test_collision();
      logic [15:0] want;
      enable_writeback = 1'b1; W_Control = 2'b00; aluout = 16'h0011; dr = 3'd5;
      step();
      enable_writeback = 1'b1; W_Control = 2'b00; aluout = 16'h00AA; dr = 3'd5;
      sr1 = 3'd5; sr2 = 3'd5;
      #1;
      want = BYPASS ? 16'h00AA : 16'h0011;
      total++;
      if (VSR1 !== want || VSR2 !== want || psr !== 3'b001) begin
         bad++;
         $display("FAIL collision_same_cycle got VSR1=%h VSR2=%h psr=%b want %h %h 001",
                  VSR1, VSR2, psr, want, want);
      end
      step();
      enable_writeback = 1'b0;
      #1;
      total++;
      if (VSR1 !== 16'h00AA || VSR2 !== 16'h00AA) begin
         bad++;
         $display("FAIL collision_next_cycle got VSR1=%h VSR2=%h want 00aa 00aa", VSR1, VSR2);
      end
   endtask

   // Random back-to-back traffic, reads checked before each edge and psr after
   task automatic test_back_to_back();
      logic [15:0] e1;
      logic [15:0] e2;
      for (int n = 0; n < 300; n++) begin
         enable_writeback = ($urandom_range(0, 3) != 0);
         W_Control        = 2'($urandom_range(0, 3));
         aluout           = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         memout           = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         pcout            = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
         dr               = 3'($urandom_range(0, 7));
         sr1              = ($urandom_range(0, 3) == 0) ? dr : 3'($urandom_range(0, 7));
         sr2              = ($urandom_range(0, 3) == 0) ? sr1 : 3'($urandom_range(0, 7));
         #1;
         e1 = exp_read(sr1);
         e2 = exp_read(sr2);
         total++;
         if (VSR1 !== e1 || VSR2 !== e2) begin
            bad++;
            $display("FAIL rand_read n=%0d sr1=%0d sr2=%0d got %h %h want %h %h",
                     n, sr1, sr2, VSR1, VSR2, e1, e2);
         end
         step();
         total++;
         if (psr !== ref_psr) begin
            bad++;
            $display("FAIL rand_psr n=%0d got %b want %b", n, psr, ref_psr);
         end
      end
      enable_writeback = 1'b0;
      for (int i = 0; i < 8; i++) begin
         sr1 = 3'(i);
         sr2 = 3'(i);
         #1;
         total++;
         if (VSR1 !== ref_rf[i] || VSR2 !== ref_rf[i]) begin
            bad++;
            $display("FAIL rand_final r%0d got %h %h want %h", i, VSR1, VSR2, ref_rf[i]);
         end
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_alu_mem();
      test_zero_pc();
      test_reserved();
      test_mid_reset();
      test_collision();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lc3_writeback_stage.md
Name: lc3_writeback_stage

Overview:
Final pipeline stage of the LC-3 core.
- Selects the writeback value (ALU, memory or PC-based result).
- Writes the value into an 8x16 general register file.
- Updates the NZP condition codes.
- Drives the writeback_out bus (psr, VSR1, VSR2) back to decode/execute.

Parameters:
- DATA_W, 16, register and datapath width.
- NUM_REGS, 8, register file depth; index width is log2(NUM_REGS) = 3.

Ports:
- clock  input  1  stage clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- enable_writeback  input  1  qualifies a register write in this cycle.
- W_Control  input  2  source select: 00 aluout, 01 memout, 10 pcout, 11 reserved.
- aluout  input  DATA_W  execute-stage result.
- memout  input  DATA_W  memory read data.
- pcout  input  DATA_W  PC-relative/link value.
- dr  input  3  destination register index.
- sr1  input  3  read-port-1 register index.
- sr2  input  3  read-port-2 register index.
- psr  output  3  condition codes {N,Z,P}.
- VSR1  output  DATA_W  contents of RF[sr1].
- VSR2  output  DATA_W  contents of RF[sr2].

Behaviour:
Reset:
- While reset=0: all RF entries = 16'h0000 and psr = 3'b000, immediately (asynchronous).
- Consequently VSR1 = VSR2 = 16'h0000 during reset.
- Reset asserted mid-operation discards any write in flight.
- First write is accepted on the first rising edge after reset returns to 1.

Write (1-cycle latency):
- On the rising edge with enable_writeback=1 and W_Control != 11: RF[dr] <= wb_data.
- wb_data mux: 00 aluout, 01 memout, 10 pcout.
- Written value becomes visible on VSR1/VSR2 from the following cycle.

PSR update:
- Occurs on the same edge as a write, computed from wb_data.
- wb_data[15]=1 -> 3'b100.
- wb_data==0 -> 3'b010.
- Otherwise -> 3'b001.
- Exactly one bit is set after any write.

No-write cycles:
- enable_writeback=0 -> RF and psr hold.
- W_Control=11 -> no write, psr holds, regardless of enable.

Reads:
- VSR1 = RF[sr1] and VSR2 = RF[sr2], purely combinational from registered state.
- sr1==sr2 returns the same value on both ports.
- Read and write to the same index in one cycle: read returns the old value (unless the optional bypass is compiled in).

Other rules:
- No arithmetic on the data; full DATA_W is passed through unmodified.
- No wrap or overflow cases apply.
- Every index 0..7 is writable; there is no hardwired zero register.
- psr reflects only the most recent qualified write; reads never alter it.
- Back-to-back writes every cycle are supported with no stall.

Optional Feature:
Macro: LC3_WB_BYPASS_EN
- Defined: combinational write-through forwarding.
- When enable_writeback=1, W_Control!=11 and sr1==dr, VSR1 = wb_data in the same cycle; sr2 is handled the same way for VSR2.
- psr is unaffected by the bypass and still updates at the clock edge.
- Bypass is inactive while reset=0.
- Undefined: reads always return registered RF contents (old value on a same-cycle collision).

Test Plan:
1. Reset held low, then released; sweep sr1/sr2 over 0..7 -> psr=000 and every VSR=0000.
2. ALU write: en=1, W_Control=00, aluout=16'h8000, dr=3; next cycle sr1=3 -> VSR1=8000, psr=100. Then memout=16'h0005, W_Control=01, dr=4 -> VSR2(sr2=4)=0005, psr=001.
3. Zero and PC writes: W_Control=10, pcout=16'h0000, dr=7 -> psr=010, RF[7]=0. Then en=0, aluout=16'h1234, dr=7 -> RF[7] stays 0000, psr stays 010.
4. Reserved select: en=1, W_Control=11, dr=2, aluout=16'hFFFF -> RF[2] unchanged, psr unchanged.
5. Mid-stream reset: write R1=16'hABCD, assert reset between edges -> VSR(R1)=0000 and psr=000 immediately, before the next edge.
6. Same-cycle collision: en=1, dr=sr1=5, aluout=16'h00AA (R5 previously 0011) -> with LC3_WB_BYPASS_EN, VSR1=00AA in the same cycle; without it, VSR1=0011 then 00AA next cycle.
